// File: rtl/sseg_num_display.sv
// Binary-to-seven-segment display driver, hex or decimal (double-dabble) mode.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits.
module sseg_num_display #(
    parameter int DATA_W     = 8,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    mode,
    input  logic [DATA_W-1:0]       bin,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic                    busy,
    output logic                    done,
    output logic                    ovf,
    output logic [8*NUM_DIGITS-1:0] hex_out
);

    // Enough BCD digits for any DATA_W-bit value plus one spare, so nothing truncates.
    localparam int BCD_DIGITS = (DATA_W * 30103 + 99999) / 100000 + 1;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int HEX_W      = 4 * NUM_DIGITS;
    localparam int CNT_W      = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_UPDATE
    } state_t;

    state_t                  state_q, state_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    ovf_q, ovf_d;
    logic [8*NUM_DIGITS-1:0] hex_q, hex_d;
    logic                    mode_q, mode_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [DATA_W-1:0]       bin_q, bin_d;
    logic [DATA_W-1:0]       shift_q, shift_d;
    logic [BCD_W-1:0]        bcd_q, bcd_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [BCD_W-1:0]        bcd_adj;
    logic [DATA_W+HEX_W-1:0] bin_ext;
    logic [BCD_W+HEX_W-1:0]  bcd_ext;
    logic [HEX_W-1:0]        digits_src;
    logic                    res_ovf;
    logic [8*NUM_DIGITS-1:0] res_hex;
    logic [7:0]              seg;

    function automatic logic [7:0] seg7(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Add-3 correction applied before each shift of the double-dabble step.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned k = 0; k < BCD_DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
    end

    // Result formatting; only consumed in ST_UPDATE.
    always_comb begin
        bin_ext    = {{HEX_W{1'b0}}, bin_q};
        bcd_ext    = {{HEX_W{1'b0}}, bcd_q};
        digits_src = mode_q ? bcd_ext[HEX_W-1:0] : bin_ext[HEX_W-1:0];
        res_ovf    = mode_q ? |(bcd_ext >> HEX_W) : |(bin_ext >> HEX_W);
        res_hex    = '1;
        seg        = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            seg = seg7(digits_src[4*i +: 4]);
            if (res_ovf) begin
                seg = 8'hBF;
            end
`ifdef LEADING_ZERO_BLANK_EN
            else if (i != 0 && (digits_src >> (4*i)) == '0) begin
                seg = 8'hFF;
            end
`endif
            seg[7] = seg[7] & ~dp_q[i];
            res_hex[8*i +: 8] = seg;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        hex_d   = hex_q;
        mode_d  = mode_q;
        dp_d    = dp_q;
        bin_d   = bin_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d = mode;
                    bin_d  = bin;
                    dp_d   = dp_in;
                    if (mode) begin
                        bcd_d   = '0;
                        shift_d = bin;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_UPDATE;
                    end
                end
            end
            ST_SHIFT: begin
                {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    busy_d  = 1'b0;
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                hex_d   = res_hex;
                ovf_d   = res_ovf;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            hex_q   <= '1;
            mode_q  <= 1'b0;
            dp_q    <= '0;
            bin_q   <= '0;
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            hex_q   <= hex_d;
            mode_q  <= mode_d;
            dp_q    <= dp_d;
            bin_q   <= bin_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign ovf     = ovf_q;
    assign hex_out = hex_q;

endmodule
